cold_buffer_loader: RTL and testbench
=====================================

// Module: cold_buffer_loader
// PURPOSE
// Write-side front end of the ColdBuffer. Accepts a DMA beat stream (BEAT_WORDS x 32-bit per beat) and packs
// beats into full 256-word rows. Issues one single-cycle row write (write_en/idx/in) per completed row.
// Writes land at consecutive buffer indices from a commanded base. A read arbiter uses busy to keep read_en low
// while a load is in flight.
// PARAMETERS
// WORD_W      32   bits per word (matches buffer entry width)
// ROW_WORDS   256  words per buffer row (u*f = 16*16)
// DEPTH       128  buffer rows; IDX_W = $clog2(DEPTH) = 7
// BEAT_WORDS  8    words per input beat; ROW_WORDS % BEAT_WORDS == 0, BEATS_PER_ROW = 32
// PORTS
// clk            in   1                    clock, all logic on rising edge
// rst            in   1                    asynchronous, active-low reset
// cmd_valid      in   1                    load command present
// cmd_ready      out  1                    loader idle, command accepted when valid&ready
// cmd_base_idx   in   IDX_W                first buffer row to write
// cmd_rows       in   IDX_W+1              rows to load, 0..128
// s_valid        in   1                    beat valid
// s_ready        out  1                    beat accepted when valid&ready
// s_data         in   [BEAT_WORDS][WORD_W] beat; s_data[k] becomes row word beat_cnt*BEAT_WORDS+k
// wr_en          out  1                    to buffer write_en
// wr_idx         out  IDX_W                to buffer idx
// wr_data        out  [ROW_WORDS][WORD_W]  to buffer in
// busy           out  1                    high in any state except IDLE
// done           out  1                    one-cycle pulse at end of command
// BEHAVIOUR
// - Reset (any time, incl. mid-row): state=IDLE; beat_cnt, row_cnt, base, rows, wr_en, wr_idx, done and busy all 0.
//   wr_data row register is cleared to 0. A partially assembled row is discarded and never written.
// - Reset values: cmd_ready=1, s_ready=0.
// - States: IDLE, FILL, WRITE, DONE.
// - IDLE:
//   - cmd_ready=1.
//   - On cmd_valid, latch base and rows. Go to DONE if cmd_rows==0, else go to FILL with beat_cnt=0, row_cnt=0.
// - FILL:
//   - s_ready=1. Each accepted beat writes words [beat_cnt*BEAT_WORDS +: BEAT_WORDS] of the row register.
//   - beat_cnt then increments.
//   - When the beat with beat_cnt==BEATS_PER_ROW-1 is accepted, go to WRITE. beat_cnt wraps to 0.
//   - s_valid low stalls indefinitely with no timeout.
// - WRITE (1 cycle):
//   - wr_en=1, wr_idx=(base+row_cnt) mod DEPTH (7-bit wrap, 127 -> 0), wr_data=row register. s_ready=0.
//   - If row_cnt==rows-1 go to DONE, else row_cnt++ and go to FILL.
// - DONE (1 cycle): done=1, then go to IDLE.
// - Outputs are registered. wr_en rises the cycle after the last beat of a row is accepted.
// - wr_en, wr_idx and wr_data are held stable for exactly that one cycle.
// - Throughput: 33 cycles per row at full s_valid rate. The row register is not double-buffered.
// - wr_idx holds its last value when wr_en=0. done and wr_en are never high in the same cycle.
// - cmd_valid outside IDLE is ignored (cmd_ready=0). Beats while s_ready=0 are not consumed.
// - cmd_rows>128 is illegal: the loader clamps it to 128.
// STRUCTURE
// - Shared package cold_buffer_pkg holds:
//   - constants WORD_W, ROW_WORDS, DEPTH, IDX_W, BEAT_WORDS, BEATS_PER_ROW
//   - typedef word_t, row_t (ROW_WORDS x word_t), beat_t
//   - enum ld_state_e {IDLE, FILL, WRITE, DONE}
// - One sub-module, cold_row_packer: row register plus beat_cnt; it inserts a beat at the slot and flags the last beat.
// - The top level holds the FSM, row_cnt, and index/handshake generation.
// TESTING
// Bench compares against a behavioural 128x256 buffer model driven by wr_en/wr_idx/wr_data.
// 1. Single row: cmd base=5 rows=1, 32 back-to-back beats, word w = w -> one wr_en at idx 5 the cycle after
//    beat 31; row[w]=w; done 2 cycles after beat 31; cmd_ready=1 next cycle.
// 2. Wrap: base=126 rows=4 -> wr_idx sequence 126,127,0,1; exactly 4 wr_en pulses; rows land in those indices.
// 3. Backpressure: s_valid randomly low 50% -> same data as the no-stall run; no beat is dropped or duplicated;
//    s_ready=0 during WRITE/DONE.
// 4. Zero rows: cmd rows=0 -> no wr_en, done pulse 1 cycle after acceptance, s_ready stays 0.
// 5. Reset mid-row: 10 beats in, assert rst -> wr_en=0, busy=0, cmd_ready=1. A fresh cmd base=0 rows=1 with new
//    data writes only the new data; no residue from the aborted row appears.
// 6. Command during busy: cmd_valid held while loading -> not accepted until done. It is then accepted in the
//    IDLE cycle after DONE.

Source files
------------

// File: rtl/cold_buffer_pkg.sv
// Shared types and constants for the ColdBuffer write-side loader.
package cold_buffer_pkg;

  localparam int WORD_W        = 32;
  localparam int ROW_WORDS     = 256;
  localparam int DEPTH         = 128;
  localparam int IDX_W         = $clog2(DEPTH);
  localparam int BEAT_WORDS    = 8;
  localparam int BEATS_PER_ROW = ROW_WORDS / BEAT_WORDS;
  localparam int BEAT_CNT_W    = $clog2(BEATS_PER_ROW);

  typedef logic [WORD_W-1:0]     word_t;
  typedef word_t [ROW_WORDS-1:0]  row_t;
  typedef word_t [BEAT_WORDS-1:0] beat_t;
  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [IDX_W:0]        rows_t;
  typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } ld_state_e;

  // Row counts above the buffer depth are saturated to a full-buffer load.
  function automatic rows_t clamp_rows(input rows_t rows);
    return (rows > rows_t'(DEPTH)) ? rows_t'(DEPTH) : rows;
  endfunction

endpackage

// File: rtl/cold_row_packer.sv
// Assembles BEATS_PER_ROW input beats into one row register and flags the
// beat that completes the row.
module cold_row_packer
  import cold_buffer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  input  logic  beat_valid,
  input  beat_t beat,
  output row_t  row,
  output logic  last_beat
);

  beat_cnt_t beat_cnt;

  // Storing the row as an array of beats makes beat i land on words
  // [i*BEAT_WORDS +: BEAT_WORDS] of the flat row without any index arithmetic.
  beat_t [BEATS_PER_ROW-1:0] beats_q;

  assign row       = beats_q;
  assign last_beat = (beat_cnt == beat_cnt_t'(BEATS_PER_ROW - 1));

  // Beat slot counter; wraps to 0 naturally after the last beat of a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (start) begin
      beat_cnt <= '0;
    end else if (beat_valid) begin
      beat_cnt <= beat_cnt + beat_cnt_t'(1);
    end
  end

  // Row register: each accepted beat overwrites its slot.
  // NOTE: this wide register is reset on purpose so an aborted row can never
  // leak stale words onto wr_data; plain RAM storage would normally not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
    end else if (beat_valid) begin
      beats_q[beat_cnt] <= beat;
    end
  end

endmodule

// File: rtl/cold_buffer_loader.sv
// Write-side front end of the ColdBuffer: packs DMA beats into full rows and
// issues one single-cycle row write per completed row at consecutive indices.
module cold_buffer_loader
  import cold_buffer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  cmd_valid,
  output logic  cmd_ready,
  input  idx_t  cmd_base_idx,
  input  rows_t cmd_rows,
  input  logic  s_valid,
  output logic  s_ready,
  input  beat_t s_data,
  output logic  wr_en,
  output idx_t  wr_idx,
  output row_t  wr_data,
  output logic  busy,
  output logic  done
);

  ld_state_e state_q, state_d;
  idx_t      base_q;
  rows_t     rows_q;
  idx_t      row_cnt_q;
  idx_t      wr_idx_q;
  logic      cmd_accept;
  logic      beat_accept;
  logic      last_beat;
  logic      last_row;

  assign cmd_accept  = cmd_valid && cmd_ready;
  assign beat_accept = s_valid && s_ready;
  assign last_row    = ({1'b0, row_cnt_q} == (rows_q - rows_t'(1)));
  assign wr_idx      = wr_idx_q;

  cold_row_packer u_packer (
    .clk        (clk),
    .rst_n      (rst),
    .start      (cmd_accept),
    .beat_valid (beat_accept),
    .beat       (s_data),
    .row        (wr_data),
    .last_beat  (last_beat)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded handshake/strobe outputs.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_d = (cmd_rows == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && last_beat) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = last_row ? DONE : FILL;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command latch, row counter and write index; wr_idx holds between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q    <= '0;
      rows_q    <= '0;
      row_cnt_q <= '0;
      wr_idx_q  <= '0;
    end else begin
      if (cmd_accept) begin
        base_q    <= cmd_base_idx;
        rows_q    <= clamp_rows(cmd_rows);
        row_cnt_q <= '0;
      end
      // Index is captured as the row completes so it is valid during WRITE;
      // the 7-bit sum wraps 127 -> 0 by construction.
      if (state_q == FILL && beat_accept && last_beat) begin
        wr_idx_q <= base_q + row_cnt_q;
      end
      if (state_q == WRITE && !last_row) begin
        row_cnt_q <= row_cnt_q + idx_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_cold_buffer_loader.sv
// Self-checking bench for cold_buffer_loader: random beat streams are checked
// against a 128-row buffer model and the expected row/index layout of each load.
module tb_cold_buffer_loader;
  import cold_buffer_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  cmd_valid = 1'b0;
  logic  cmd_ready;
  idx_t  cmd_base_idx = '0;
  rows_t cmd_rows = '0;
  logic  s_valid = 1'b0;
  logic  s_ready;
  beat_t s_data = '0;
  logic  wr_en;
  idx_t  wr_idx;
  row_t  wr_data;
  logic  busy;
  logic  done;

  cold_buffer_loader dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base_idx (cmd_base_idx),
    .cmd_rows     (cmd_rows),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests  = 0;
  int n_failed = 0;

  // Behavioural buffer and per-command scoreboard state.
  row_t  mem [DEPTH];
  word_t exp_words[$];
  int    wr_log_idx[$];
  int    wr_log_cyc[$];
  int    done_cnt      = 0;
  int    done_cyc      = 0;
  int    acc_cyc       = 0;
  int    last_beat_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and record what the DUT shows there.
  task automatic tick();
    @(negedge clk);
    if (wr_en) begin
      mem[wr_idx] = wr_data;
      wr_log_idx.push_back(int'(wr_idx));
      wr_log_cyc.push_back(cyc);
      check("s_ready low during write", s_ready, 0);
      check("done low during write", done, 0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("s_ready low during done", s_ready, 0);
    end
  endtask

  task automatic reset_logs();
    exp_words.delete();
    wr_log_idx.delete();
    wr_log_cyc.delete();
    done_cnt = 0;
  endtask

  // Present a command and return in the cycle after it was accepted.
  task automatic issue(input int base, input int rows, input bit hold);
    int budget = 0;
    cmd_base_idx = idx_t'(base);
    cmd_rows     = rows_t'(rows);
    cmd_valid    = 1'b1;
    while (!cmd_ready && budget < 20000) begin
      tick();
      budget++;
    end
    check("cmd_ready before accept", cmd_ready, 1);
    tick();
    acc_cyc = cyc;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Offer beats until n have been accepted; unaccepted beats carry fresh junk.
  task automatic stream(input int n, input int stall_pct, input bit ramp);
    int    sent   = 0;
    int    budget = 0;
    beat_t b;
    while (sent < n && budget < 20000) begin
      for (int k = 0; k < BEAT_WORDS; k++) begin
        b[k] = ramp ? word_t'(sent * BEAT_WORDS + k) : word_t'($urandom());
      end
      s_data  = b;
      s_valid = ($urandom_range(99) >= stall_pct);
      if (s_valid && s_ready) begin
        for (int k = 0; k < BEAT_WORDS; k++) exp_words.push_back(b[k]);
        sent++;
        last_beat_cyc = cyc;
      end
      tick();
      budget++;
    end
    s_valid = 1'b0;
    check("beats accepted", sent, n);
  endtask

  task automatic wait_done();
    int budget = 0;
    while (done_cnt == 0 && budget < 1000) begin
      tick();
      budget++;
    end
  endtask

  // Compare the logged writes and the buffer model against the expected layout.
  task automatic verify(input string tag, input int base, input int rows);
    int eff;
    int idx;
    int bad;
    eff = (rows > DEPTH) ? DEPTH : rows;
    check({tag, " write count"}, wr_log_idx.size(), eff);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " words sent"}, exp_words.size(), eff * ROW_WORDS);
    for (int r = 0; r < eff; r++) begin
      idx = (base + r) % DEPTH;
      if (r < wr_log_idx.size()) begin
        check($sformatf("%s wr_idx[%0d]", tag, r), wr_log_idx[r], idx);
      end
      bad = 0;
      for (int w = 0; w < ROW_WORDS; w++) begin
        if (r * ROW_WORDS + w >= exp_words.size() ||
            mem[idx][w] !== exp_words[r * ROW_WORDS + w]) bad++;
      end
      check($sformatf("%s row %0d bad words", tag, idx), bad, 0);
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) tick();
    check("reset cmd_ready", cmd_ready, 1);
    check("reset s_ready", s_ready, 0);
    check("reset busy", busy, 0);
    check("reset wr_en", wr_en, 0);
    check("reset done", done, 0);
    check("reset wr_idx", wr_idx, 0);
    check("reset wr_data", |wr_data, 0);
    rst = 1'b1;
    tick();

    // Single row with a word ramp and exact latencies.
    reset_logs();
    issue(5, 1, 1'b0);
    stream(BEATS_PER_ROW, 0, 1'b1);
    wait_done();
    verify("single", 5, 1);
    if (wr_log_cyc.size() > 0) check("single wr_en latency", wr_log_cyc[0] - last_beat_cyc, 1);
    check("single done latency", done_cyc - last_beat_cyc, 2);
    tick();
    check("single cmd_ready after done", cmd_ready, 1);

    // Index wrap 126,127,0,1.
    reset_logs();
    issue(126, 4, 1'b0);
    stream(4 * BEATS_PER_ROW, 0, 1'b0);
    wait_done();
    verify("wrap", 126, 4);
    tick();

    // Backpressure at 50% valid.
    reset_logs();
    issue(30, 3, 1'b0);
    stream(3 * BEATS_PER_ROW, 50, 1'b0);
    wait_done();
    verify("stall", 30, 3);
    tick();

    // Zero-row command.
    reset_logs();
    issue(9, 0, 1'b0);
    check("zero done pulse", done_cnt, 1);
    check("zero done latency", done_cyc - acc_cyc, 0);
    check("zero s_ready in done", s_ready, 0);
    s_valid = 1'b1;
    repeat (3) tick();
    s_valid = 1'b0;
    check("zero writes", wr_log_idx.size(), 0);
    check("zero single done", done_cnt, 1);
    check("zero s_ready idle", s_ready, 0);
    check("zero cmd_ready idle", cmd_ready, 1);

    // Reset in the middle of a row, then a fresh load.
    reset_logs();
    issue(0, 1, 1'b0);
    stream(10, 0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst wr_en", wr_en, 0);
    check("midrst busy", busy, 0);
    check("midrst cmd_ready", cmd_ready, 1);
    check("midrst s_ready", s_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst no write", wr_log_idx.size(), 0);
    reset_logs();
    issue(0, 1, 1'b0);
    stream(BEATS_PER_ROW, 0, 1'b0);
    wait_done();
    verify("midrst fresh", 0, 1);
    tick();

    // Command held valid during a load is taken only in the IDLE cycle after DONE.
    reset_logs();
    issue(40, 1, 1'b1);
    cmd_base_idx = idx_t'(60);
    cmd_rows     = rows_t'(1);
    stream(BEATS_PER_ROW, 0, 1'b0);
    check("hold cmd_ready busy", cmd_ready, 0);
    wait_done();
    check("hold cmd_ready in done", cmd_ready, 0);
    verify("hold first", 40, 1);
    reset_logs();
    tick();
    check("hold idle cmd_ready", cmd_ready, 1);
    tick();
    check("hold second accepted", busy, 1);
    cmd_valid = 1'b0;
    stream(BEATS_PER_ROW, 0, 1'b0);
    wait_done();
    verify("hold second", 60, 1);
    tick();

    // Oversized row count saturates to a full-buffer load.
    reset_logs();
    issue(64, 200, 1'b0);
    stream(DEPTH * BEATS_PER_ROW, 0, 1'b0);
    wait_done();
    verify("clamp", 64, 200);
    tick();

    // Random commands with random backpressure.
    for (int i = 0; i < 4; i++) begin
      int base;
      int rows;
      base = $urandom_range(DEPTH - 1);
      rows = $urandom_range(3, 1);
      reset_logs();
      issue(base, rows, 1'b0);
      stream(rows * BEATS_PER_ROW, $urandom_range(70), 1'b0);
      wait_done();
      verify($sformatf("rand%0d", i), base, rows);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
